// File: rtl/tick_sched_pkg.sv
// Shared state type, default parameters and burst-length helper for tick_sched.
package tick_sched_pkg;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_BURST_W = 4;
  localparam int DEF_CYC_W   = 32;
  localparam int DEF_MAX_CYC = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DONE
  } state_t;

  // A programmed length of zero still yields a single grant cycle.
  function automatic logic [31:0] clamp_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_sum    = '0;
    w_pos    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(NREQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NREQ);
      end
      w_pos = w_sum[IDX_W-1:0];
      if (!o_valid && i_req[w_pos]) begin
        o_valid         = 1'b1;
        o_idx           = w_pos;
        o_onehot[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_sched.sv
// Cycle-budgeted round-robin burst scheduler sharing one clock-enable slot among NREQ requesters.
// Optional trace/assertion build: define TICK_SCHED_TRACE_EN.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int BURST_W = DEF_BURST_W,
  parameter int CYC_W   = DEF_CYC_W,
  parameter int MAX_CYC = DEF_MAX_CYC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BURST_W-1:0]  burst_len,
  output logic [NREQ-1:0]          gnt,
  output logic                     gnt_first,
  output logic                     gnt_last,
  output logic                     busy,
  output logic [CYC_W-1:0]         cyc,
  output logic                     done
);

  localparam int               IDX_W     = $clog2(NREQ);
  localparam bit               HAS_LIMIT = (MAX_CYC != 0);
  localparam logic [CYC_W-1:0] LIMIT     = CYC_W'(MAX_CYC);
  localparam logic [CYC_W-1:0] LIMIT_M1  = CYC_W'(MAX_CYC - 1);

  state_t             r_state, w_stateNext;
  logic [NREQ-1:0]    r_gnt, w_gntNext;
  logic               r_first, w_firstNext;
  logic               r_last, w_lastNext;
  logic [BURST_W-1:0] r_remain, w_remainNext;
  logic [IDX_W-1:0]   r_ptr, w_ptrNext;
  logic [CYC_W-1:0]   r_cyc;

  logic [NREQ-1:0]    w_pickOnehot;
  logic [IDX_W-1:0]   w_pickIdx;
  logic [IDX_W-1:0]   w_ptrInc;
  logic               w_pickValid;
  logic [BURST_W-1:0] w_lenRaw;
  logic [BURST_W-1:0] w_len;
  logic               w_done;
  logic               w_doneEdge;
  logic               w_start;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pickOnehot),
    .o_idx    (w_pickIdx),
    .o_valid  (w_pickValid)
  );

  assign w_lenRaw   = burst_len[w_pickIdx*BURST_W +: BURST_W];
  assign w_len      = BURST_W'(clamp_len(32'(w_lenRaw)));
  assign w_ptrInc   = (w_pickIdx == IDX_W'(NREQ - 1)) ? '0 : w_pickIdx + IDX_W'(1);
  assign w_done     = HAS_LIMIT && (r_cyc == LIMIT);
  assign w_doneEdge = HAS_LIMIT && !w_done && (r_cyc == LIMIT_M1);

  // r_remain counts grant cycles left including the current one.
  always_comb begin
    w_stateNext  = r_state;
    w_gntNext    = '0;
    w_firstNext  = 1'b0;
    w_lastNext   = 1'b0;
    w_remainNext = r_remain;
    w_ptrNext    = r_ptr;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: w_start = w_pickValid;
      ST_GRANT: begin
        if (r_remain > BURST_W'(1)) begin
          w_gntNext    = r_gnt;
          w_remainNext = r_remain - BURST_W'(1);
          w_lastNext   = (r_remain == BURST_W'(2));
        end else if (w_pickValid) begin
          w_start = 1'b1;
        end else begin
          w_stateNext  = ST_IDLE;
          w_remainNext = '0;
        end
      end
      default: ;
    endcase
    // Budget exhaustion truncates any burst and overrides a new grant.
    if (w_doneEdge || r_state == ST_DONE) begin
      w_stateNext  = ST_DONE;
      w_gntNext    = '0;
      w_firstNext  = 1'b0;
      w_lastNext   = 1'b0;
      w_remainNext = '0;
      w_start      = 1'b0;
    end else if (w_start) begin
      w_stateNext  = ST_GRANT;
      w_gntNext    = w_pickOnehot;
      w_firstNext  = 1'b1;
      w_lastNext   = (w_len == BURST_W'(1));
      w_remainNext = w_len;
      w_ptrNext    = w_ptrInc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_remain <= '0;
      r_ptr    <= '0;
      r_cyc    <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_gnt    <= w_gntNext;
      r_first  <= w_firstNext;
      r_last   <= w_lastNext;
      r_remain <= w_remainNext;
      r_ptr    <= w_ptrNext;
      if (!w_done) begin
        r_cyc <= r_cyc + CYC_W'(1);
      end
    end
  end

  assign gnt       = r_gnt;
  assign gnt_first = r_first;
  assign gnt_last  = r_last;
  assign busy      = (r_state == ST_GRANT);
  assign cyc       = r_cyc;
  assign done      = w_done;

`ifdef TICK_SCHED_TRACE_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (w_start) $write("[%0t] grant %0d len %0d\n", $time, w_pickIdx, w_len);
      if (w_doneEdge) $write("*-* All Finished *-*\n");
      assert ($onehot0(gnt)) else $error("gnt is not one-hot-or-zero");
    end
  end
`else
`endif

endmodule
